// File: rtl/lsu_mem_stage.sv
// MEM stage of the load/store unit: IDLE/REQ/WAIT bus sequencer with registered MEM/WB entry.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module lsu_mem_stage #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] alu_result_i,
  input  logic [31:0]       rs2_data_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              reg_write_i,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i,
  output logic              wb_valid_o,
  output logic [31:0]       wb_result_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic              wb_reg_write_o,
  output logic              exc_o,
  output logic [1:0]        exc_cause_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYC);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic MIS_TRAP = 1'b1;
`else
  localparam logic MIS_TRAP = 1'b0;
`endif

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we, r_uns, r_rw;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_off, r_sz;
  logic [4:0]        r_rd;
  logic              r_wb_valid, r_wb_rw, r_exc;
  logic [31:0]       r_wb_result;
  logic [4:0]        r_wb_rd;
  logic [1:0]        r_exc_cause;

  logic [1:0]   w_sz, w_off;
  logic         w_uns, w_mis, w_accept, w_is_mem, w_timeout, w_done;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata, w_lane, w_load;
  logic [CNT_W:0] w_cnt_inc;

  always_comb begin
    w_sz  = SZ_W;
    w_uns = 1'b0;
    case (funct3_i)
      3'b000: w_sz = SZ_B;
      3'b001: w_sz = SZ_H;
      3'b100: begin w_sz = SZ_B; w_uns = 1'b1; end
      3'b101: begin w_sz = SZ_H; w_uns = 1'b1; end
      default: ;
    endcase
  end

  // Offset with the misaligned low bits dropped; only used when no trap is taken.
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = rs2_data_i;
    case (w_sz)
      SZ_B: begin
        w_off   = alu_result_i[1:0];
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{rs2_data_i[7:0]}};
      end
      SZ_H: begin
        w_off   = {alu_result_i[1], 1'b0};
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{rs2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_mis    = ((w_sz == SZ_H) && alu_result_i[0]) ||
                    ((w_sz == SZ_W) && (alu_result_i[1:0] != 2'b00));
  assign w_is_mem = mem_read_i | mem_write_i;
  assign w_accept = in_valid_i && (r_state == S_IDLE);

  assign w_lane = data_rdata_i >> {r_off, 3'b000};
  always_comb begin
    w_load = data_rdata_i;
    case (r_sz)
      SZ_B: w_load = r_uns ? {24'b0, w_lane[7:0]}   : {{24{w_lane[7]}}, w_lane[7:0]};
      SZ_H: w_load = r_uns ? {16'b0, w_lane[15:0]}  : {{16{w_lane[15]}}, w_lane[15:0]};
      default: ;
    endcase
  end

  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_inc == TO_LIM);
  assign w_done    = ((r_state == S_REQ) && data_gnt_i && data_rvalid_i) ||
                     ((r_state == S_WAIT) && data_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_rw        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_off       <= '0;
      r_sz        <= '0;
      r_rd        <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_result <= '0;
      r_wb_rd     <= '0;
      r_wb_rw     <= 1'b0;
      r_exc       <= 1'b0;
      r_exc_cause <= '0;
    end else begin
      r_wb_valid  <= 1'b0;
      r_exc       <= 1'b0;
      r_exc_cause <= 2'b00;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (!w_is_mem) begin
            r_wb_valid  <= 1'b1;
            r_wb_result <= 32'(alu_result_i);
            r_wb_rd     <= rd_addr_i;
            r_wb_rw     <= reg_write_i;
          end else if (MIS_TRAP && w_mis) begin
            r_exc       <= 1'b1;
            r_exc_cause <= 2'b01;
          end else begin
            r_state <= S_REQ;
            r_cnt   <= '0;
            r_we    <= mem_write_i;
            r_uns   <= w_uns;
            r_rw    <= reg_write_i;
            r_be    <= w_be;
            r_addr  <= {alu_result_i[ADDR_W-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_off   <= w_off;
            r_sz    <= w_sz;
            r_rd    <= rd_addr_i;
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            r_cnt   <= '0;
            r_state <= data_rvalid_i ? S_IDLE : S_WAIT;
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_exc       <= 1'b1;
            r_exc_cause <= 2'b10;
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end
        S_WAIT: begin
          if (data_rvalid_i) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_state     <= S_IDLE;
            r_exc       <= 1'b1;
            r_exc_cause <= 2'b10;
          end else begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Stores leave the previous wb_result in place; only the tag fields update.
      if (w_done) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_rw    <= r_rw & ~r_we;
        if (!r_we) r_wb_result <= w_load;
      end
    end
  end

  assign in_ready_o     = (r_state == S_IDLE);
  assign data_req_o     = (r_state == S_REQ);
  assign data_we_o      = r_we;
  assign data_be_o      = r_be;
  assign data_addr_o    = r_addr;
  assign data_wdata_o   = r_wdata;
  assign wb_valid_o     = r_wb_valid;
  assign wb_result_o    = r_wb_result;
  assign wb_rd_addr_o   = r_wb_rd;
  assign wb_reg_write_o = r_wb_rw;
  assign exc_o          = r_exc;
  assign exc_cause_o    = r_exc_cause;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed + randomized bench for lsu_mem_stage (TIMEOUT_CYC=4) against an arithmetic access model.
module tb_lsu_mem_stage;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic [31:0] alu_result_i = '0, rs2_data_i = '0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        reg_write_i = 1'b0;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        wb_valid_o, wb_reg_write_o, exc_o;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rd_addr_o;
  logic [1:0]  exc_cause_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res = '0;

  lsu_mem_stage #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .rd_addr_i(rd_addr_i),
    .reg_write_i(reg_write_i), .data_req_o(data_req_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_reg_write_o(wb_reg_write_o), .exc_o(exc_o), .exc_cause_o(exc_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access model: size in bytes, offset aligned down to the size, lanes by arithmetic.
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input int off, input int n,
                                             input logic [2:0] f3);
    longint v, span;
    span = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * off)) % span;
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input int n);
    if (n == 1) return {24'b0, rs2[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'b0, rs2[15:0]} * 32'h0001_0001;
    return rs2;
  endfunction

  task automatic do_mem(input string nm, input logic [31:0] a, input logic [2:0] f3, input bit st,
                        input logic [31:0] rs2, input logic [31:0] rdat, input logic [4:0] rd,
                        input bit rw, input int gd, input int rvd);
    int n, off;
    bit mis, trap;
    n    = nbytes(f3);
    off  = (a % 4) - ((a % 4) % n);
    mis  = ((a % 4) % n) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    chk({nm, ".rdy0"}, 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1; alu_result_i = a; rs2_data_i = rs2; funct3_i = f3;
    mem_write_i = st; mem_read_i = st ? 1'($urandom % 2) : 1'b1;
    rd_addr_i = rd; reg_write_i = rw;
    tick();
    in_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    alu_result_i = $urandom; rs2_data_i = $urandom; funct3_i = 3'($urandom);
    if (trap) begin
      chk({nm, ".mexc"}, 32'(exc_o), 32'd1);
      chk({nm, ".mcause"}, 32'(exc_cause_o), 32'd1);
      chk({nm, ".mreq"}, 32'(data_req_o), 32'd0);
      chk({nm, ".mwb"}, 32'(wb_valid_o), 32'd0);
      tick();
      chk({nm, ".mreq2"}, 32'(data_req_o), 32'd0);
      return;
    end
    for (int k = 0; k <= gd; k++) begin
      chk({nm, ".req"}, 32'(data_req_o), 32'd1);
      chk({nm, ".rdy"}, 32'(in_ready_o), 32'd0);
      chk({nm, ".addr"}, data_addr_o, a & 32'hFFFF_FFFC);
      chk({nm, ".be"}, 32'(data_be_o), ((32'd1 << n) - 32'd1) << off);
      chk({nm, ".we"}, 32'(data_we_o), 32'(st));
      if (st) chk({nm, ".wdata"}, data_wdata_o, model_wdata(rs2, n));
      data_gnt_i    = (k == gd);
      data_rvalid_i = (k == gd) && (rvd == 0);
      data_rdata_i  = data_rvalid_i ? rdat : $urandom;
      tick();
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    for (int k = 1; k <= rvd; k++) begin
      chk({nm, ".wreq"}, 32'(data_req_o), 32'd0);
      chk({nm, ".wrdy"}, 32'(in_ready_o), 32'd0);
      chk({nm, ".wwb"}, 32'(wb_valid_o), 32'd0);
      data_rvalid_i = (k == rvd);
      data_rdata_i  = data_rvalid_i ? rdat : $urandom;
      tick();
    end
    data_rvalid_i = 1'b0; data_rdata_i = $urandom;
    chk({nm, ".wbv"}, 32'(wb_valid_o), 32'd1);
    chk({nm, ".wbrd"}, 32'(wb_rd_addr_o), 32'(rd));
    chk({nm, ".wbrw"}, 32'(wb_reg_write_o), st ? 32'd0 : 32'(rw));
    chk({nm, ".exc"}, 32'(exc_o), 32'd0);
    chk({nm, ".rdy1"}, 32'(in_ready_o), 32'd1);
    if (!st) begin
      last_res = model_load(rdat, off, n, f3);
      chk({nm, ".wbres"}, wb_result_o, last_res);
    end
    tick();
    chk({nm, ".pulse"}, 32'(wb_valid_o), 32'd0);
    if (!st) chk({nm, ".hold"}, wb_result_o, last_res);
  endtask

  task automatic do_alu(input string nm, input logic [31:0] v, input logic [4:0] rd, input bit rw);
    in_valid_i = 1'b1; alu_result_i = v; mem_read_i = 1'b0; mem_write_i = 1'b0;
    rd_addr_i = rd; reg_write_i = rw;
    tick();
    in_valid_i = 1'b0; alu_result_i = $urandom;
    last_res = v;
    chk({nm, ".wbv"}, 32'(wb_valid_o), 32'd1);
    chk({nm, ".res"}, wb_result_o, v);
    chk({nm, ".rd"}, 32'(wb_rd_addr_o), 32'(rd));
    chk({nm, ".rw"}, 32'(wb_reg_write_o), 32'(rw));
    chk({nm, ".req"}, 32'(data_req_o), 32'd0);
    chk({nm, ".rdy"}, 32'(in_ready_o), 32'd1);
    tick();
    chk({nm, ".pulse"}, 32'(wb_valid_o), 32'd0);
    chk({nm, ".hold"}, wb_result_o, v);
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    // Reset state
    tick(); tick();
    chk("rst.rdy", 32'(in_ready_o), 32'd1);
    chk("rst.wbv", 32'(wb_valid_o), 32'd0);
    chk("rst.res", wb_result_o, 32'd0);
    chk("rst.req", 32'(data_req_o), 32'd0);
    chk("rst.be", 32'(data_be_o), 32'd0);
    chk("rst.addr", data_addr_o, 32'd0);
    chk("rst.exc", 32'(exc_o), 32'd0);
    rst_i = 1'b0;
    tick();

    do_alu("alu0", 32'hDEAD_BEEF, 5'd7, 1'b1);
    do_mem("lb103", 32'h0000_0103, 3'b000, 1'b0, 32'h0, 32'h80AB_CDEF, 5'd3, 1'b1, 0, 1);
    do_mem("sh202", 32'h0000_0202, 3'b001, 1'b1, 32'h1234_5678, 32'h0, 5'd4, 1'b1, 0, 0);
    do_mem("lwdly", 32'h0000_0040, 3'b010, 1'b0, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1, 3, 2);
    do_mem("lw101", 32'h0000_0101, 3'b010, 1'b0, 32'h0, 32'h1357_9BDF, 5'd10, 1'b1, 1, 1);

    // Grant never arrives: timeout after four cycles in REQ.
    in_valid_i = 1'b1; alu_result_i = 32'h0000_0080; mem_read_i = 1'b1; funct3_i = 3'b010;
    rd_addr_i = 5'd1; reg_write_i = 1'b1;
    tick();
    in_valid_i = 1'b0; mem_read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to.req", 32'(data_req_o), 32'd1);
      chk("to.exc0", 32'(exc_o), 32'd0);
      tick();
    end
    chk("to.exc", 32'(exc_o), 32'd1);
    chk("to.cause", 32'(exc_cause_o), 32'd2);
    chk("to.wbv", 32'(wb_valid_o), 32'd0);
    chk("to.rdy", 32'(in_ready_o), 32'd1);
    chk("to.req1", 32'(data_req_o), 32'd0);
    tick();
    chk("to.pulse", 32'(exc_o), 32'd0);

    // Reset while waiting for rvalid; the late rvalid must be dropped.
    in_valid_i = 1'b1; alu_result_i = 32'h0000_0100; mem_read_i = 1'b1; funct3_i = 3'b010;
    tick();
    in_valid_i = 1'b0; mem_read_i = 1'b0;
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    chk("rw.inwait", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    last_res = '0;
    chk("rw.rdy", 32'(in_ready_o), 32'd1);
    chk("rw.res", wb_result_o, 32'd0);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
    tick();
    data_rvalid_i = 1'b0;
    chk("rw.wbv", 32'(wb_valid_o), 32'd0);
    chk("rw.exc", 32'(exc_o), 32'd0);
    chk("rw.rdy2", 32'(in_ready_o), 32'd1);
    tick();
    chk("rw.wbv2", 32'(wb_valid_o), 32'd0);

    // Randomized mix of loads, stores and ALU ops.
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 4);
      if (kind == 0)
        do_alu("ralu", $urandom, 5'($urandom), 1'($urandom));
      else
        do_mem("rmem", $urandom, f3s[$urandom_range(0, 7)], kind >= 3, $urandom, $urandom,
               5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: data-bus address width; data width is fixed at 32.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: maximum number of cycles spent waiting for gnt or rvalid; 0 disables the timeout.
REQ-003 SHALL have port clk_i, input, 1: clock; every flop updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i / in_ready_o, input / output, 1 / 1: handshake for the EX/MEM entry.
REQ-006 SHALL have port alu_result_i, input, ADDR_W: effective address, or the ALU result for non-memory ops.
REQ-007 SHALL have port rs2_data_i, input, 32: store data.
REQ-008 SHALL have port mem_read_i / mem_write_i, input, 1 each: load / store; both high is treated as a store.
REQ-009 SHALL have port funct3_i, input, 3: access size; 000=B, 001=H, 010=W, 100=BU, 101=HU; any other code is treated as W.
REQ-010 SHALL have port rd_addr_i / reg_write_i, input, 5 / 1: writeback tag.
REQ-011 SHALL have ports data_req_o, data_we_o, data_be_o[3:0], data_addr_o[ADDR_W-1:0], data_wdata_o[31:0] (outputs) and data_gnt_i, data_rvalid_i, data_rdata_i[31:0] (inputs): data-bus interface.
REQ-012 SHALL have port wb_valid_o, wb_result_o[31:0], wb_rd_addr_o[4:0], wb_reg_write_o, output: registered MEM/WB entry.
REQ-013 SHALL have port exc_o / exc_cause_o[1:0], output: one-cycle exception pulse; cause 01 = misaligned, 10 = bus timeout.

Function
REQ-014 SHALL use a state machine with states IDLE, REQ and WAIT; in_ready_o is 1 only in IDLE.
REQ-015 Non-memory op accepted in IDLE SHALL produce wb_valid_o=1 on the next cycle, with wb_result_o=alu_result_i; the FSM stays in IDLE.
REQ-016 Memory op accepted in IDLE SHALL latch the address, byte enables, store data, size and tag, then enter REQ.
REQ-017 In REQ, data_req_o SHALL be 1 and the bus outputs SHALL be held stable; on data_gnt_i the FSM goes to WAIT (or to IDLE if data_rvalid_i is also high that cycle).
REQ-018 In WAIT, on data_rvalid_i the FSM SHALL return to IDLE; wb_valid_o is pulsed on the next cycle.
REQ-019 A store SHALL produce wb_valid_o with wb_reg_write_o=0.
REQ-020 data_addr_o SHALL equal the latched address with bits [1:0] cleared.
REQ-021 Byte enables SHALL be: B = 0001<<a[1:0]; H = 0011<<(2*a[1]); W = 1111.
REQ-022 Store data SHALL be replicated across lanes: B = {4{rs2[7:0]}}; H = {2{rs2[15:0]}}.
REQ-023 Load data SHALL take the lane selected by a[1:0], then sign-extend for B/H or zero-extend for BU/HU.
REQ-024 A timeout counter SHALL reset on entry to REQ and on gnt; if it reaches TIMEOUT_CYC in REQ or WAIT, the block pulses exc_o with cause 10, suppresses wb_valid_o and returns to IDLE.
REQ-025 Outputs wb_* SHALL hold their last values when wb_valid_o=0; wb_valid_o is a single-cycle pulse per op.

Reset
REQ-026 While rst_i is high, the FSM SHALL go to IDLE, the counter is cleared, and all outputs are 0 except in_ready_o=1 (from the first cycle after reset).
REQ-027 Reset asserted in REQ or WAIT SHALL abort the op with no wb_valid_o and no exc_o; a later rvalid for the aborted op is ignored in IDLE.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN SHALL control misaligned accesses (H with a[0]=1, W with a[1:0]!=0).
REQ-029 With LSU_MISALIGN_TRAP_EN defined, a misaligned access SHALL issue no bus request, pulse exc_o with cause 01 on the cycle after accept, and suppress wb_valid_o.
REQ-030 Without LSU_MISALIGN_TRAP_EN, the offending low address bits SHALL be forced to 0 and the access proceeds normally; exc_o cause 01 is never produced.

Verification
REQ-031 LB at address 0x103, rdata=0x80AB_CDEF -> be=1000, addr=0x100, wb_result=0xFFFF_FF80.
REQ-032 SH at address 0x202, rs2=0x1234_5678 -> be=1100, wdata=0x5678_5678, wb_reg_write=0.
REQ-033 LW with gnt delayed 3 cycles and rvalid 2 cycles after that -> data_req held 4 cycles with stable outputs, in_ready=0 throughout, one wb_valid pulse.
REQ-034 LW at 0x101 -> with the macro: exc_o with cause 01, no data_req. Without the macro: addr=0x100, normal completion.
REQ-035 TIMEOUT_CYC=4, gnt never asserted -> exc_o with cause 10 after 4 cycles in REQ, FSM back in IDLE.
REQ-036 rst_i pulsed during WAIT, then rvalid arrives -> no wb_valid, no exc_o, in_ready=1.
